// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Mask codes, FSM states and fault bit positions.
package lsu_pkg;

   localparam int XLEN   = 64;
   localparam int MASK_W = XLEN / 8;

   localparam logic [MASK_W-1:0] MSK_BYTE = 8'h01;
   localparam logic [MASK_W-1:0] MSK_HALF = 8'h03;
   localparam logic [MASK_W-1:0] MSK_WORD = 8'h0F;
   localparam logic [MASK_W-1:0] MSK_DBL  = 8'hFF;

   localparam int FLT_MISALIGN = 0;
   localparam int FLT_ACC      = 1;
   localparam int FLT_W        = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_OUT
   } lsu_state_t;

   function automatic logic mask_legal(input logic [MASK_W-1:0] m);
      return (m == MSK_BYTE) || (m == MSK_HALF) ||
             (m == MSK_WORD) || (m == MSK_DBL);
   endfunction

   // Access size minus one: the offset bits that must be zero.
   function automatic logic [2:0] size_lsb(input logic [MASK_W-1:0] m);
      case (m)
         MSK_HALF: return 3'd1;
         MSK_WORD: return 3'd3;
         MSK_DBL:  return 3'd7;
         default:  return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for stores, extraction/extension for loads,
// and the misalignment check for an incoming memory op.
module lsu_align
   import lsu_pkg::*;
(
   input  logic              ren,
   input  logic              wen,
   input  logic [2:0]        st_off,
   input  logic [MASK_W-1:0] st_mask,
   input  logic [XLEN-1:0]   st_wdata,
   output logic [XLEN-1:0]   st_data,
   output logic [MASK_W-1:0] st_strb,
   output logic              misalign,
   input  logic [2:0]        ld_off,
   input  logic [MASK_W-1:0] ld_mask,
   input  logic              ld_signed,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   ld_data
);

   logic [2:0]      st_lsb;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] byte_mask;
   logic            sign;

   assign st_lsb   = size_lsb(st_mask);
   assign misalign = (ren | wen) &
                     ((ren & wen) | !mask_legal(st_mask) |
                      ((st_off & st_lsb) != 3'd0));
   assign st_data  = st_wdata << {st_off, 3'b000};
   assign st_strb  = st_mask << st_off;

   always_comb begin
      shifted   = rdata >> {ld_off, 3'b000};
      byte_mask = '0;
      for (int i = 0; i < MASK_W; i++) begin
         byte_mask[8*i +: 8] = {8{ld_mask[i]}};
      end
      case (ld_mask)
         MSK_BYTE: sign = shifted[7];
         MSK_HALF: sign = shifted[15];
         MSK_WORD: sign = shifted[31];
         default:  sign = shifted[XLEN-1];
      endcase
      ld_data = shifted & byte_mask;
      if (ld_signed && sign) begin
         ld_data = ld_data | ~byte_mask;
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned 64-bit request per memory op over a
// valid/ready port, writeback packet to WBU; non-mem ops pass through.
module lsu
   import lsu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              renMem_i,
   input  logic              wenMem_i,
   input  logic [MASK_W-1:0] mask_i,
   input  logic              is_load_signed_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [XLEN-1:0]   alu_res_i,
   input  logic [4:0]        rd_i,
   input  logic              wenReg_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [XLEN-1:0]   mem_req_addr_o,
   output logic              mem_req_wen_o,
   output logic [XLEN-1:0]   mem_req_wdata_o,
   output logic [MASK_W-1:0] mem_req_wstrb_o,
   input  logic              mem_resp_valid_i,
   output logic              mem_resp_ready_o,
   input  logic [XLEN-1:0]   mem_resp_rdata_i,
   input  logic              mem_resp_err_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   out_data_o,
   output logic [4:0]        out_rd_o,
   output logic              out_wenReg_o,
   output logic              out_misalign_o,
   output logic              out_acc_fault_o
);

   lsu_state_t        state;
   logic              ren_q;
   logic              sgn_q;
   logic [2:0]        off_q;
   logic [MASK_W-1:0] mask_q;
   logic [4:0]        rd_q;
   logic              wen_reg_q;
   logic [FLT_W-1:0]  flt_q;

   logic [XLEN-1:0]   st_data;
   logic [MASK_W-1:0] st_strb;
   logic              misalign;
   logic [XLEN-1:0]   ld_data;

   lsu_align u_align (
      .ren       (renMem_i),
      .wen       (wenMem_i),
      .st_off    (addr_i[2:0]),
      .st_mask   (mask_i),
      .st_wdata  (wdata_i),
      .st_data   (st_data),
      .st_strb   (st_strb),
      .misalign  (misalign),
      .ld_off    (off_q),
      .ld_mask   (mask_q),
      .ld_signed (sgn_q),
      .rdata     (mem_resp_rdata_i),
      .ld_data   (ld_data)
   );

   assign in_ready_o      = (state == S_IDLE);
   assign out_misalign_o  = flt_q[FLT_MISALIGN];
   assign out_acc_fault_o = flt_q[FLT_ACC];

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= S_IDLE;
         ren_q            <= 1'b0;
         sgn_q            <= 1'b0;
         off_q            <= '0;
         mask_q           <= '0;
         rd_q             <= '0;
         wen_reg_q        <= 1'b0;
         flt_q            <= '0;
         mem_req_valid_o  <= 1'b0;
         mem_req_addr_o   <= '0;
         mem_req_wen_o    <= 1'b0;
         mem_req_wdata_o  <= '0;
         mem_req_wstrb_o  <= '0;
         mem_resp_ready_o <= 1'b0;
         out_valid_o      <= 1'b0;
         out_data_o       <= '0;
         out_rd_o         <= '0;
         out_wenReg_o     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid_i) begin
                  ren_q     <= renMem_i;
                  sgn_q     <= is_load_signed_i;
                  off_q     <= addr_i[2:0];
                  mask_q    <= mask_i;
                  rd_q      <= rd_i;
                  wen_reg_q <= wenReg_i;
                  if (misalign) begin
                     flt_q        <= '0;
                     flt_q[FLT_MISALIGN] <= 1'b1;
                     out_valid_o  <= 1'b1;
                     out_data_o   <= '0;
                     out_rd_o     <= rd_i;
                     out_wenReg_o <= 1'b0;
                     state        <= S_OUT;
                  end else if (!renMem_i && !wenMem_i) begin
                     flt_q        <= '0;
                     out_valid_o  <= 1'b1;
                     out_data_o   <= alu_res_i;
                     out_rd_o     <= rd_i;
                     out_wenReg_o <= wenReg_i;
                     state        <= S_OUT;
                  end else begin
                     mem_req_valid_o <= 1'b1;
                     mem_req_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
                     mem_req_wen_o   <= wenMem_i;
                     mem_req_wdata_o <= wenMem_i ? st_data : '0;
                     mem_req_wstrb_o <= wenMem_i ? st_strb : '0;
                     state           <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_o  <= 1'b0;
                  mem_resp_ready_o <= 1'b1;
                  state            <= S_RESP;
               end
            end
            S_RESP: begin
               if (mem_resp_valid_i) begin
                  mem_resp_ready_o <= 1'b0;
                  out_valid_o      <= 1'b1;
                  out_rd_o         <= rd_q;
                  flt_q            <= '0;
                  if (mem_resp_err_i) begin
                     flt_q[FLT_ACC] <= 1'b1;
                     out_data_o     <= '0;
                     out_wenReg_o   <= 1'b0;
                  end else if (ren_q) begin
                     out_data_o     <= ld_data;
                     out_wenReg_o   <= wen_reg_q;
                  end else begin
                     out_data_o     <= '0;
                     out_wenReg_o   <= 1'b0;
                  end
                  state <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit consuming the decoder's memory-op controls: read/write enable, size mask and load-signedness.
- Issues one aligned 64-bit request per instruction over a valid/ready memory port.
- Aligns store lanes and extracts and extends load data.
- Returns a writeback packet to WBU. Non-memory instructions pass through with 1-cycle latency.

Parameters:
- XLEN, 64, data and address width
- MASK_W, 8, byte-strobe width (XLEN/8)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid_i  in  1  upstream packet valid
- in_ready_o  out  1  LSU can accept a packet
- renMem_i  in  1  load
- wenMem_i  in  1  store
- mask_i  in  MASK_W  size mask: 0x01 byte, 0x03 half, 0x0F word, 0xFF double
- is_load_signed_i  in  1  sign-extend load result
- addr_i  in  XLEN  effective address from ALU
- wdata_i  in  XLEN  store data (rs2 value)
- alu_res_i  in  XLEN  result for non-memory instructions
- rd_i  in  5  destination register
- wenReg_i  in  1  register write enable
- mem_req_valid_o  out  1  request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  XLEN  addr with bits [2:0] forced to 0
- mem_req_wen_o  out  1  1 = write
- mem_req_wdata_o  out  XLEN  lane-shifted store data
- mem_req_wstrb_o  out  MASK_W  mask_i << addr[2:0]
- mem_resp_valid_i  in  1  response valid
- mem_resp_ready_o  out  1  LSU accepts response
- mem_resp_rdata_i  in  XLEN  read data, full 8-byte line
- mem_resp_err_i  in  1  access fault
- out_valid_o  out  1  writeback packet valid
- out_ready_i  in  1  WBU accepts packet
- out_data_o  out  XLEN  load result or alu_res
- out_rd_o  out  5  destination register
- out_wenReg_o  out  1  register write enable
- out_misalign_o  out  1  misaligned or illegal mask
- out_acc_fault_o  out  1  memory returned error

Behaviour:
- Reset (synchronous, active-high, wins over all events): state=IDLE; all *_valid_o, mem_resp_ready_o, fault outputs and out_wenReg_o = 0; data, addr and strb outputs = 0.
- Reset mid-transaction abandons it. The memory side shares the reset, so no stale response survives.
- FSM states: IDLE, REQ, RESP, OUT.
  - in_ready_o = (state==IDLE). Accept = in_valid_i & in_ready_o; all inputs are latched on accept.
  - IDLE→OUT on accept when renMem_i=wenMem_i=0: out_data=alu_res_i, rd and wenReg pass through.
  - IDLE→OUT on accept with a fault, no memory access, out_wenReg=0, out_data=0. Fault conditions:
    - renMem_i & wenMem_i both set, or mask_i not one of the 4 legal codes → out_misalign=1.
    - addr_i[2:0] & (popcount(mask)-1) != 0 → out_misalign=1. Natural alignment guarantees no 8-byte crossing.
  - IDLE→REQ otherwise.
  - REQ: mem_req_valid_o=1, all request fields stable until mem_req_ready_i. On fire → RESP.
    - Store: wdata = wdata_i << (8*addr[2:0]); wstrb = mask << addr[2:0].
    - Load: wstrb = 0.
  - RESP: mem_resp_ready_o=1. On mem_resp_valid_i → OUT.
    - Load: raw = rdata >> (8*addr[2:0]) & byte-mask expanded, then sign-extended from the top selected bit if is_load_signed, else zero-extended.
    - Store: out_data=0, out_wenReg=0.
    - mem_resp_err_i=1: out_acc_fault=1, out_wenReg=0, out_data=0.
  - OUT: out_valid_o=1, packet stable until out_ready_i; on fire → IDLE. Back-to-back accept occurs the cycle after.
- Latency:
  - Non-memory: accept at cycle N, out_valid at N+1.
  - Memory with zero-wait memory: req_valid at N+1, resp at N+2, out_valid at N+3.
- mem_req_valid_o never drops without a handshake. Only one outstanding request.

Decomposition:
- Shared defines header:
  - XLEN.
  - Mask encodings: byte/half/word/double.
  - LSU state encoding.
  - Fault bit positions.
- Sub-module lsu_align (combinational):
  - Store path: addr offset + mask + wdata → wdata/wstrb.
  - Load path: offset + mask + signed + rdata → extended result.
  - Also produces the misalign flag.
  - Instanced once in lsu.

Test Plan:
- Non-mem: alu_res=0x1234, rd=5, wenReg=1 → out_valid next cycle, data=0x1234, rd=5, no mem_req_valid.
- sb addr=0x8000_0003 wdata=0xAB → mem_req addr=0x8000_0000, wstrb=0x08, wdata=0x00000000AB000000, wen=1; out_wenReg=0.
- lh signed addr=0x...06, rdata=0x8001_xxxx_xxxx_xxxx → out_data=0xFFFF_FFFF_FFFF_8001. Same with lhu → 0x8001.
- lw addr=0x...02 → out_misalign=1, no mem_req_valid, out_wenReg=0. ld addr=0x...08 → legal.
- Backpressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles → request and out packet held stable, in_ready_o=0 throughout.
- Reset asserted in RESP with response pending, then mem_resp_err=1 on a later ld → after reset all valids=0 and state IDLE. Later ld yields out_acc_fault=1, data=0.
